axi4_lite_slave_mem: RTL

- Synthesizable, parametrised AXI4-Lite slave backed by a byte-addressable word memory.
- Used as the memory-side responder for the AXI4-Lite master peripheral, both in simulation benches and in hardware.
- Generalises the fixed one-cycle handshake responder with:
  - configurable data/address width, depth and read/write latency;
  - independent AW/W acceptance;
  - SLVERR for out-of-range accesses.

---
 rtl/axi4_lite_slave_mem.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/axi4_lite_slave_mem.sv
// axi4_lite_slave_mem: AXI4-Lite slave backed by a byte-strobed word memory
// Ports: alm_aclk / alm_aresetn (async active-low) clock and reset;
//        AW/W/B write channels, each address/data channel with a one-entry hold;
//        AR/R read channel; indices at or above DEPTH answer SLVERR (2'b10).
// Build option: define AXI4_LITE_SLAVE_MEM_STALL_EN to gate the readies with
//        a free-running LFSR for random backpressure.
module axi4_lite_slave_mem #(
  parameter int DW     = 32,
  parameter int AW     = 7,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 0,
  parameter int WR_LAT = 0
) (
  input  logic            alm_aclk,
  input  logic            alm_aresetn,
  input  logic            alm_awvalid,
  output logic            alm_awready,
  input  logic [AW-1:0]   alm_awaddr,
  input  logic            alm_wvalid,
  output logic            alm_wready,
  input  logic [DW-1:0]   alm_wdata,
  input  logic [DW/8-1:0] alm_wstrb,
  output logic [1:0]      alm_bresp,
  output logic            alm_bvalid,
  input  logic            alm_bready,
  input  logic            alm_arvalid,
  output logic            alm_arready,
  input  logic [AW-1:0]   alm_araddr,
  output logic            alm_rvalid,
  input  logic            alm_rready,
  output logic [DW-1:0]   alm_rdata,
  output logic [1:0]      alm_rresp
);
  localparam int NB = $clog2(DW / 8);
  localparam int XW = AW - NB;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int SW = DW / 8;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  logic [DW-1:0] mem [DEPTH];
  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic [3:0] w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
  logic aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic aw_rdy_q, w_rdy_q, ar_rdy_q, rvalid_q, rvalid_d;
  logic [XW-1:0] aw_idx_q, aw_idx_d, ar_idx_q, ar_idx_d;
  logic [DW-1:0] w_data_q, w_data_d, rdata_q, rdata_d;
  logic [SW-1:0] w_strb_q, w_strb_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic aw_hs, w_hs, ar_hs, commit, sample, aw_ok, ar_ok;
  logic [2:0] stall;
`ifdef AXI4_LITE_SLAVE_MEM_STALL_EN
  logic [15:0] lfsr_q;
  // Galois form of x^16+x^14+x^13+x^11+1
  always_ff @(posedge alm_aclk or negedge alm_aresetn)
    if (!alm_aresetn) lfsr_q <= 16'hACE1;
    else lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign stall = lfsr_q[2:0];
`else
  assign stall = 3'b000;
`endif
  assign alm_awready = aw_rdy_q & ~stall[0];
  assign alm_wready  = w_rdy_q & ~stall[1];
  assign alm_arready = ar_rdy_q & ~stall[2];
  assign alm_bvalid  = w_state_q == W_RESP;
  assign alm_bresp   = bresp_q;
  assign alm_rvalid  = rvalid_q;
  assign alm_rdata   = rdata_q;
  assign alm_rresp   = rresp_q;
  always_comb begin
    aw_hs = alm_awvalid & alm_awready;
    w_hs = alm_wvalid & alm_wready;
    ar_hs = alm_arvalid & alm_arready;
    aw_ok = 32'(aw_idx_q) < 32'(DEPTH);
    ar_ok = 32'(ar_idx_q) < 32'(DEPTH);
    // holds only drain while the write FSM is idle; a full hold refuses new beats
    commit = (w_state_q == W_IDLE) & aw_full_q & w_full_q;
    aw_full_d = aw_hs | (aw_full_q & ~commit);
    w_full_d = w_hs | (w_full_q & ~commit);
    // shift the whole address so the ignored byte-offset bits are simply dropped
    aw_idx_d = aw_hs ? XW'(alm_awaddr >> NB) : aw_idx_q;
    w_data_d = w_hs ? alm_wdata : w_data_q;
    w_strb_d = w_hs ? alm_wstrb : w_strb_q;
    bresp_d = commit ? (aw_ok ? 2'b00 : 2'b10) : bresp_q;
    w_cnt_d = w_state_q == W_WAIT ? w_cnt_q + 4'd1 : 4'd0;
    w_state_d = commit ? (WR_LAT == 0 ? W_RESP : W_WAIT)
              : (w_state_q == W_WAIT && w_cnt_q == 4'(WR_LAT - 1)) ? W_RESP
              : (w_state_q == W_RESP && alm_bready) ? W_IDLE : w_state_q;
    ar_idx_d = ar_hs ? XW'(alm_araddr >> NB) : ar_idx_q;
    r_cnt_d = r_state_q == R_WAIT ? r_cnt_q + 4'd1 : 4'd0;
    // memory is sampled on the first edge spent in R_RESP, so rvalid trails AR by RD_LAT+1
    sample = (r_state_q == R_RESP) & ~rvalid_q;
    rvalid_d = sample | (rvalid_q & ~alm_rready);
    rdata_d = sample ? (ar_ok ? mem[ar_idx_q[IW-1:0]] : '0) : rdata_q;
    rresp_d = sample ? (ar_ok ? 2'b00 : 2'b10) : rresp_q;
    r_state_d = ar_hs ? (RD_LAT == 0 ? R_RESP : R_WAIT)
              : (r_state_q == R_WAIT && r_cnt_q == 4'(RD_LAT - 1)) ? R_RESP
              : (r_state_q == R_RESP && rvalid_q && alm_rready) ? R_IDLE : r_state_q;
  end
  always_ff @(posedge alm_aclk or negedge alm_aresetn)
    if (!alm_aresetn) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      w_cnt_q   <= '0;
      r_cnt_q   <= '0;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_rdy_q  <= 1'b0;
      w_rdy_q   <= 1'b0;
      ar_rdy_q  <= 1'b0;
      aw_idx_q  <= '0;
      ar_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      w_cnt_q   <= w_cnt_d;
      r_cnt_q   <= r_cnt_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      aw_rdy_q  <= ~aw_full_d;
      w_rdy_q   <= ~w_full_d;
      ar_rdy_q  <= r_state_d == R_IDLE;
      aw_idx_q  <= aw_idx_d;
      ar_idx_q  <= ar_idx_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  // storage is deliberately left out of reset
  always_ff @(posedge alm_aclk)
    if (commit && aw_ok)
      for (int i = 0; i < SW; i++)
        if (w_strb_q[i]) mem[aw_idx_q[IW-1:0]][8*i +: 8] <= w_data_q[8*i +: 8];
endmodule
